// File: rtl/riscv_lsu.sv
// Load/store unit: request/response handshake between the MEM stage and a variable-latency
// data memory, with byte enables, sub-word extension, misalignment checks and an ack timeout.
module riscv_lsu #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [DATA_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                stall,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_wr,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wr_data,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rd_data
);

  localparam int unsigned BW = DATA_W / 8;
  localparam int unsigned LG = $clog2(BW);
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("riscv_lsu: DATA_W must be 32 or 64");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("riscv_lsu: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [LG-1:0]       lane_q, lane_d;
  logic [1:0]          size_q, size_d;
  logic                sign_q, sign_d;
  logic                we_q, we_d;
  logic                mem_wr_q, mem_wr_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BW-1:0]       mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

  logic [LG-1:0]       req_lane;
  logic [1:0]          req_size;
  logic                req_legal;
  logic                req_aligned;
  logic [LG-1:0]       align_mask;
  logic [BW-1:0]       size_mask;
  logic [DATA_W-1:0]   req_wdata_rep;
  logic [DATA_W-1:0]   rd_shifted;
  logic [DATA_W-1:0]   rd_ext;
  logic                rd_fill;
  int unsigned         rd_nbits;

  // Upper address bits select nothing in this memory map.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[DATA_W-1:ADDR_W+LG];

  assign req_lane = req_addr[LG-1:0];
  assign req_size = req_funct3[1:0];

  // Request decode: legality, alignment, byte enables and lane-replicated store data.
  always_comb begin
    req_legal = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: req_legal = 1'b1;
        3'b011:                 req_legal = (DATA_W == 64);
        default:                req_legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
        3'b011, 3'b110:                         req_legal = (DATA_W == 64);
        default:                                req_legal = 1'b0;
      endcase
    end

    align_mask = '0;
    for (int unsigned i = 0; i < LG; i++) begin
      align_mask[i] = (i < 32'(req_size));
    end
    req_aligned = ((req_lane & align_mask) == '0);

    size_mask = '0;
    for (int unsigned i = 0; i < BW; i++) begin
      size_mask[i] = (i < (32'd1 << req_size));
    end

    case (req_size)
      2'd0:    req_wdata_rep = {BW{req_wdata[7:0]}};
      2'd1:    req_wdata_rep = {(BW / 2){req_wdata[15:0]}};
      2'd2:    req_wdata_rep = {(BW / 4){req_wdata[31:0]}};
      default: req_wdata_rep = req_wdata;
    endcase
  end

  // Load data: bring the addressed lane down to bit 0, then sign/zero extend.
  always_comb begin
    rd_shifted = mem_rd_data >> {lane_q, 3'b000};
    rd_nbits   = 32'd8 << size_q;
    case (size_q)
      2'd0:    rd_fill = sign_q & rd_shifted[7];
      2'd1:    rd_fill = sign_q & rd_shifted[15];
      2'd2:    rd_fill = sign_q & rd_shifted[31];
      default: rd_fill = sign_q & rd_shifted[DATA_W-1];
    endcase
    rd_ext = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      rd_ext[i] = (i < rd_nbits) ? rd_shifted[i] : rd_fill;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lane_d        = lane_q;
    size_d        = size_q;
    sign_d        = sign_q;
    we_d          = we_q;
    mem_wr_d      = mem_wr_q;
    mem_rd_d      = mem_rd_q;
    mem_addr_d    = mem_addr_q;
    mem_be_d      = mem_be_q;
    mem_wr_data_d = mem_wr_data_q;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    resp_rdata_d  = '0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_legal && req_aligned) begin
            state_d       = StAccess;
            cnt_d         = '0;
            lane_d        = req_lane;
            size_d        = req_size;
            sign_d        = ~req_funct3[2];
            we_d          = req_we;
            mem_wr_d      = req_we;
            mem_rd_d      = ~req_we;
            mem_addr_d    = req_addr[ADDR_W+LG-1:LG];
            mem_be_d      = size_mask << req_lane;
            mem_wr_data_d = req_wdata_rep;
          end else begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end
      StAccess: begin
        if (mem_ack) begin
          state_d      = StResp;
          mem_wr_d     = 1'b0;
          mem_rd_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? '0 : rd_ext;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TimeoutCnt) begin
            state_d      = StResp;
            mem_wr_d     = 1'b0;
            mem_rd_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      lane_q        <= '0;
      size_q        <= '0;
      sign_q        <= 1'b0;
      we_q          <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_be_q      <= '0;
      mem_wr_data_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lane_q        <= lane_d;
      size_q        <= size_d;
      sign_q        <= sign_d;
      we_q          <= we_d;
      mem_wr_q      <= mem_wr_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      mem_be_q      <= mem_be_d;
      mem_wr_data_q <= mem_wr_data_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_rdata_q  <= resp_rdata_d;
    end
  end

  // Stall drops in the response cycle so the pipeline advances with resp_rdata.
  assign req_ready   = (state_q == StIdle);
  assign stall       = (state_q == StAccess) | ((state_q == StIdle) & req_valid);
  assign mem_wr      = mem_wr_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wr_data = mem_wr_data_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: a 32-bit instance (TIMEOUT=4) and a 64-bit instance, with a
// response scoreboard per instance.
module tb_riscv_lsu;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        req_valid = 0, req_ready, req_we = 0, stall;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        resp_valid, resp_err, mem_wr, mem_rd, mem_ack = 0;
  logic [31:0] resp_rdata, mem_wr_data, mem_rd_data = 0;
  logic [8:0]  mem_addr;
  logic [3:0]  mem_be;

  // 64-bit instance
  logic        w_req_valid = 0, w_req_ready, w_req_we = 0, w_stall;
  logic [2:0]  w_req_funct3 = 0;
  logic [63:0] w_req_addr = 0, w_req_wdata = 0;
  logic        w_resp_valid, w_resp_err, w_mem_wr, w_mem_rd, w_mem_ack = 0;
  logic [63:0] w_resp_rdata, w_mem_wr_data, w_mem_rd_data = 0;
  logic [8:0]  w_mem_addr;
  logic [7:0]  w_mem_be;

  riscv_lsu #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(4)) u_dut32 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_wr(mem_wr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wr_data(mem_wr_data),
    .mem_ack(mem_ack), .mem_rd_data(mem_rd_data)
  );

  riscv_lsu #(.DATA_W(64), .ADDR_W(9), .TIMEOUT(15)) u_dut64 (
    .clk(clk), .reset(reset), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_we(w_req_we), .req_funct3(w_req_funct3), .req_addr(w_req_addr),
    .req_wdata(w_req_wdata), .stall(w_stall), .resp_valid(w_resp_valid),
    .resp_rdata(w_resp_rdata), .resp_err(w_resp_err), .mem_wr(w_mem_wr), .mem_rd(w_mem_rd),
    .mem_addr(w_mem_addr), .mem_be(w_mem_be), .mem_wr_data(w_mem_wr_data),
    .mem_ack(w_mem_ack), .mem_rd_data(w_mem_rd_data)
  );

  typedef struct packed {
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Scoreboards: every resp_valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid === 1'b1) begin
      n_cmp++;
      if (q32.size() == 0) begin
        n_bad++;
        $display("FAIL resp32_unexpected: got err=%b rdata=%h, required no response",
                 resp_err, resp_rdata);
      end else begin
        e = q32.pop_front();
        if ({resp_err, resp_rdata} !== {e.err, e.rdata[31:0]}) begin
          n_bad++;
          $display("FAIL resp32: got err=%b rdata=%h, required err=%b rdata=%h",
                   resp_err, resp_rdata, e.err, e.rdata[31:0]);
        end
      end
    end
    if (w_resp_valid === 1'b1) begin
      n_cmp++;
      if (q64.size() == 0) begin
        n_bad++;
        $display("FAIL resp64_unexpected: got err=%b rdata=%h, required no response",
                 w_resp_err, w_resp_rdata);
      end else begin
        e = q64.pop_front();
        if ({w_resp_err, w_resp_rdata} !== {e.err, e.rdata}) begin
          n_bad++;
          $display("FAIL resp64: got err=%b rdata=%h, required err=%b rdata=%h",
                   w_resp_err, w_resp_rdata, e.err, e.rdata);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One 32-bit access; ack_wait = wait cycles before ack, exp_cyc = strobe cycles required.
  task automatic access32(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rword,
                          input int ack_wait, input int exp_cyc, input logic exp_err,
                          input logic [31:0] exp_rdata, input logic [8:0] exp_maddr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input string name);
    exp_t e;
    int   cyc;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    e.err      = exp_err;
    e.rdata    = {32'd0, exp_rdata};
    q32.push_back(e);
    #1;
    n_cmp++;
    if ({req_ready, stall} !== 2'b11) begin
      n_bad++;
      $display("FAIL %s req_ready/stall: got %b%b, required 11", name, req_ready, stall);
    end
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while ((mem_rd | mem_wr) === 1'b1 && cyc < 40) begin
      if (cyc == 0) begin
        n_cmp++;
        if ({mem_wr, mem_rd, stall, req_ready} !== {we, ~we, 2'b10}) begin
          n_bad++;
          $display("FAIL %s strobes: got wr=%b rd=%b stall=%b rdy=%b, required wr=%b rd=%b 1 0",
                   name, mem_wr, mem_rd, stall, req_ready, we, ~we);
        end
        n_cmp++;
        if ({mem_addr, mem_be} !== {exp_maddr, exp_be}) begin
          n_bad++;
          $display("FAIL %s addr/be: got %h/%h, required %h/%h",
                   name, mem_addr, mem_be, exp_maddr, exp_be);
        end
        if (we) begin
          n_cmp++;
          if (mem_wr_data !== exp_wd) begin
            n_bad++;
            $display("FAIL %s wr_data: got %h, required %h", name, mem_wr_data, exp_wd);
          end
        end
      end
      if (cyc == ack_wait) begin
        mem_ack     = 1'b1;
        mem_rd_data = rword;
      end
      cyc++;
      @(negedge clk);
      mem_ack = 1'b0;
    end
    n_cmp++;
    if (cyc !== exp_cyc) begin
      n_bad++;
      $display("FAIL %s strobe_cycles: got %0d, required %0d", name, cyc, exp_cyc);
    end
    n_cmp++;
    if (resp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s resp_timing: got resp_valid=%b, required 1", name, resp_valid);
    end
    @(negedge clk);
  endtask

  task automatic access64(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] rword,
                          input logic [63:0] exp_rdata, input logic [8:0] exp_maddr,
                          input logic [7:0] exp_be, input string name);
    exp_t e;
    w_req_valid  = 1'b1;
    w_req_we     = we;
    w_req_funct3 = f3;
    w_req_addr   = addr;
    w_req_wdata  = wdata;
    e.err        = 1'b0;
    e.rdata      = exp_rdata;
    q64.push_back(e);
    @(negedge clk);
    w_req_valid = 1'b0;
    n_cmp++;
    if ({w_mem_wr, w_mem_rd, w_mem_addr, w_mem_be} !== {we, ~we, exp_maddr, exp_be}) begin
      n_bad++;
      $display("FAIL %s access: got wr=%b rd=%b addr=%h be=%h, required %b %b %h %h",
               name, w_mem_wr, w_mem_rd, w_mem_addr, w_mem_be, we, ~we, exp_maddr, exp_be);
    end
    if (we) begin
      n_cmp++;
      if (w_mem_wr_data !== wdata) begin
        n_bad++;
        $display("FAIL %s wr_data: got %h, required %h", name, w_mem_wr_data, wdata);
      end
    end
    w_mem_ack     = 1'b1;
    w_mem_rd_data = rword;
    @(negedge clk);
    w_mem_ack = 1'b0;
    n_cmp++;
    if (w_resp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s resp_timing: got resp_valid=%b, required 1", name, w_resp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({mem_wr, mem_rd, resp_valid, resp_err, mem_addr, mem_be, mem_wr_data, resp_rdata}
        !== '0) begin
      n_bad++;
      $display("FAIL reset32_outputs: got wr=%b rd=%b v=%b e=%b a=%h be=%h wd=%h rd=%h, required 0",
               mem_wr, mem_rd, resp_valid, resp_err, mem_addr, mem_be, mem_wr_data, resp_rdata);
    end
    n_cmp++;
    if ({req_ready, stall, w_req_ready, w_stall} !== 4'b1010) begin
      n_bad++;
      $display("FAIL reset_ready_stall: got %b%b%b%b, required 1010",
               req_ready, stall, w_req_ready, w_stall);
    end
    n_cmp++;
    if ({w_mem_wr, w_mem_rd, w_resp_valid, w_resp_err, w_mem_addr, w_mem_be, w_mem_wr_data,
         w_resp_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset64_outputs: got nonzero outputs, required all 0");
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store();
    access32(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, 1'b0, 32'h0, 9'd4, 4'hF,
             32'hDEADBEEF, "sw");
    access32(1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 0, 1, 1'b0, 32'h0, 9'd4, 4'h8,
             32'hA5A5A5A5, "sb");
    access32(1'b1, 3'b001, 32'h02, 32'hFFFF1234, 32'h0, 1, 2, 1'b0, 32'h0, 9'd0, 4'hC,
             32'h12341234, "sh");
  endtask

  task automatic test_load();
    access32(1'b0, 3'b000, 32'h13, 32'h0, 32'hA5000000, 0, 1, 1'b0, 32'hFFFFFFA5, 9'd4, 4'h8,
             32'h0, "lb");
    access32(1'b0, 3'b100, 32'h13, 32'h0, 32'hA5000000, 0, 1, 1'b0, 32'h000000A5, 9'd4, 4'h8,
             32'h0, "lbu");
    access32(1'b0, 3'b001, 32'h06, 32'h0, 32'h80011234, 0, 1, 1'b0, 32'hFFFF8001, 9'd1, 4'hC,
             32'h0, "lh");
    access32(1'b0, 3'b101, 32'h06, 32'h0, 32'h80011234, 2, 3, 1'b0, 32'h00008001, 9'd1, 4'hC,
             32'h0, "lhu");
    access32(1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0, 1, 1'b0, 32'hCAFEF00D, 9'd8, 4'hF,
             32'h0, "lw");
  endtask

  task automatic test_errors();
    access32(1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 9'd0, 4'h0, 32'h0,
             "lw_misaligned");
    access32(1'b0, 3'b011, 32'h08, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 9'd0, 4'h0, 32'h0,
             "ld_at_32");
    access32(1'b1, 3'b100, 32'h08, 32'h5, 32'h0, 0, 0, 1'b1, 32'h0, 9'd0, 4'h0, 32'h0,
             "store_f3_100");
    access32(1'b0, 3'b001, 32'h05, 32'h0, 32'h0, 0, 0, 1'b1, 32'h0, 9'd0, 4'h0, 32'h0,
             "lh_misaligned");
  endtask

  task automatic test_timeout();
    access32(1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 99, 4, 1'b1, 32'h0, 9'd8, 4'hF, 32'h0,
             "lw_timeout");
    access32(1'b0, 3'b010, 32'h20, 32'h0, 32'h12345678, 3, 4, 1'b0, 32'h12345678, 9'd8, 4'hF,
             32'h0, "lw_ack_at_limit");
  endtask

  // A request held through ACCESS and RESP is taken only once the unit is idle again.
  task automatic test_back_to_back();
    exp_t e;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h08;
    e.err      = 1'b0;
    e.rdata    = 64'h11223344;
    q32.push_back(e);
    @(negedge clk);
    req_funct3  = 3'b100;
    req_addr    = 32'h09;
    mem_ack     = 1'b1;
    mem_rd_data = 32'h11223344;
    n_cmp++;
    if ({req_ready, mem_rd, mem_addr} !== {1'b0, 1'b1, 9'd2}) begin
      n_bad++;
      $display("FAIL b2b_first_access: got rdy=%b rd=%b addr=%h, required 0 1 002",
               req_ready, mem_rd, mem_addr);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    n_cmp++;
    if ({req_ready, resp_valid} !== 2'b01) begin
      n_bad++;
      $display("FAIL b2b_resp: got rdy=%b valid=%b, required 0 1", req_ready, resp_valid);
    end
    @(negedge clk);
    e.rdata = 64'h33;
    q32.push_back(e);
    n_cmp++;
    if ({req_ready, stall} !== 2'b11) begin
      n_bad++;
      $display("FAIL b2b_accept: got rdy=%b stall=%b, required 1 1", req_ready, stall);
    end
    @(negedge clk);
    req_valid   = 1'b0;
    mem_ack     = 1'b1;
    mem_rd_data = 32'h11223344;
    n_cmp++;
    if ({mem_rd, mem_addr, mem_be} !== {1'b1, 9'd2, 4'h2}) begin
      n_bad++;
      $display("FAIL b2b_second_access: got rd=%b addr=%h be=%h, required 1 002 2",
               mem_rd, mem_addr, mem_be);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_second_resp: got %b, required 1", resp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (mem_rd !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_strobe: got mem_rd=%b, required 1", mem_rd);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({mem_rd, mem_wr, resp_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_mid_async: got rd=%b wr=%b valid=%b, required 000",
               mem_rd, mem_wr, resp_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({req_ready, mem_rd, resp_valid} !== 3'b100) begin
        n_bad++;
        $display("FAIL rst_mid_after[%0d]: got rdy=%b rd=%b valid=%b, required 100",
                 i, req_ready, mem_rd, resp_valid);
      end
    end
  endtask

  task automatic test_dword();
    access64(1'b0, 3'b011, 64'h08, 64'h0, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 9'd1,
             8'hFF, "ld");
    access64(1'b0, 3'b110, 64'h0C, 64'h0, 64'h8000000112345678, 64'h0000000080000001, 9'd1,
             8'hF0, "lwu");
    access64(1'b0, 3'b010, 64'h0C, 64'h0, 64'h8000000112345678, 64'hFFFFFFFF80000001, 9'd1,
             8'hF0, "lw64");
    access64(1'b1, 3'b011, 64'h10, 64'h1122334455667788, 64'h0, 64'h0, 9'd2, 8'hFF, "sd");
    access64(1'b1, 3'b000, 64'h15, 64'h7E7E7E7E7E7E7E7E, 64'h0, 64'h0, 9'd2, 8'h20, "sb64");
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_dword();
    @(negedge clk);
    n_cmp++;
    if (q32.size() != 0 || q64.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0",
               q32.size(), q64.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
